// File: rtl/noc_task_ctrl.sv
// Traffic-task controller for the 2x4 mesh: holds per-PE traffic config,
// sequences flush/run, collects finish flags and reports status and run length.
module noc_task_ctrl #(
  parameter int unsigned FLUSH_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_pe,
  input  logic [38:0]       cfg_wdata,
  input  logic              start,
  input  logic [7:0]        start_mask,
  input  logic              abort,
  output logic [7:0]        pe_enable,
  output logic [7:0]        pe_dbg_mode_wire,
  output logic [23:0]       pe_send_num_wire,
  output logic [23:0]       pe_receive_num_wire,
  output logic [31:0]       pe_rate_wire,
  output logic [191:0]      pe_dst_seq_wire,
  output logic [31:0]       pe_mode_wire,
  output logic [7:0]        pe_flush_wire,
  input  logic [7:0]        pe_task_send_finish_flag,
  input  logic [7:0]        pe_task_receive_finish_flag,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              start_err
);

  localparam int unsigned NPE  = 8;
  localparam int unsigned FW   = $clog2(FLUSH_CYCLES + 1);
  localparam logic [1:0] ST_NONE    = 2'd0;
  localparam logic [1:0] ST_OK      = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN} state_t;

  state_t         state;
  logic [7:0]     mask;
  logic [7:0]     snd;
  logic [7:0]     rcv;
  logic [FW-1:0]  flush_cnt;
  logic [7:0]     snd_nxt;
  logic [7:0]     rcv_nxt;
  logic           complete;
  logic           timeout;
  logic           end_run;
  logic [1:0]     end_status;

  // Completion looks at this cycle's flags merged with the sticky vectors
  assign snd_nxt  = snd | (pe_task_send_finish_flag & mask);
  assign rcv_nxt  = rcv | (pe_task_receive_finish_flag & mask);
  assign complete = (snd_nxt == mask) && (rcv_nxt == mask);
  assign timeout  = (run_cycles == CNT_W'(TIMEOUT_CYCLES - 1));

  // Run termination priority: abort, then completion, then timeout
  always_comb begin
    end_run    = 1'b0;
    end_status = ST_NONE;
    if (state != S_IDLE && abort) begin
      end_run    = 1'b1;
      end_status = ST_ABORT;
    end else if (state == S_RUN && complete) begin
      end_run    = 1'b1;
      end_status = ST_OK;
    end else if (state == S_RUN && timeout) begin
      end_run    = 1'b1;
      end_status = ST_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      mask                <= '0;
      snd                 <= '0;
      rcv                 <= '0;
      flush_cnt           <= '0;
      pe_enable           <= '0;
      pe_flush_wire       <= '0;
      pe_dbg_mode_wire    <= '0;
      pe_send_num_wire    <= '0;
      pe_receive_num_wire <= '0;
      pe_rate_wire        <= '0;
      pe_dst_seq_wire     <= '0;
      pe_mode_wire        <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      status              <= ST_NONE;
      run_cycles          <= '0;
      start_err           <= 1'b0;
    end else begin
      done      <= 1'b0;
      start_err <= start && (state != S_IDLE || start_mask == 8'd0);

      unique case (state)
        S_IDLE: begin
          if (cfg_wr) begin
            for (int i = 0; i < NPE; i++) begin
              if (cfg_pe == 3'(i)) begin
                pe_dbg_mode_wire[i]          <= cfg_wdata[38];
                pe_send_num_wire[3*i +: 3]    <= cfg_wdata[37:35];
                pe_receive_num_wire[3*i +: 3] <= cfg_wdata[34:32];
                pe_rate_wire[4*i +: 4]        <= cfg_wdata[31:28];
                pe_mode_wire[4*i +: 4]        <= cfg_wdata[27:24];
                pe_dst_seq_wire[24*i +: 24]   <= cfg_wdata[23:0];
              end
            end
          end
          if (start && start_mask != 8'd0) begin
            state         <= S_FLUSH;
            busy          <= 1'b1;
            mask          <= start_mask;
            pe_flush_wire <= start_mask;
            flush_cnt     <= '0;
            status        <= ST_NONE;
            run_cycles    <= '0;
            snd           <= '0;
            rcv           <= '0;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
            state         <= S_RUN;
            pe_flush_wire <= '0;
            pe_enable     <= mask;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        S_RUN: begin
          snd <= snd_nxt;
          rcv <= rcv_nxt;
          if (run_cycles != '1) run_cycles <= run_cycles + CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase

      // Ending a run overrides whatever the phase logic scheduled above
      if (end_run) begin
        state         <= S_IDLE;
        busy          <= 1'b0;
        done          <= 1'b1;
        status        <= end_status;
        pe_enable     <= '0;
        pe_flush_wire <= '0;
      end
    end
  end

endmodule

// File: tb/tb_noc_task_ctrl.sv
// Bench for noc_task_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a run-level model.
module tb_noc_task_ctrl;

  localparam int unsigned FLUSH   = 4;
  localparam int unsigned TIMEOUT = 30;
  localparam longint RUN_MAX = 64'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_wr;
  logic [2:0]   cfg_pe;
  logic [38:0]  cfg_wdata;
  logic         start;
  logic [7:0]   start_mask;
  logic         abort;
  logic [7:0]   pe_enable;
  logic [7:0]   pe_dbg_mode_wire;
  logic [23:0]  pe_send_num_wire;
  logic [23:0]  pe_receive_num_wire;
  logic [31:0]  pe_rate_wire;
  logic [191:0] pe_dst_seq_wire;
  logic [31:0]  pe_mode_wire;
  logic [7:0]   pe_flush_wire;
  logic [7:0]   sflag;
  logic [7:0]   rflag;
  logic         busy;
  logic         done;
  logic [1:0]   status;
  logic [31:0]  run_cycles;
  logic         start_err;

  int checks = 0;
  int errors = 0;

  noc_task_ctrl #(.FLUSH_CYCLES(FLUSH), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_pe(cfg_pe), .cfg_wdata(cfg_wdata),
    .start(start), .start_mask(start_mask), .abort(abort),
    .pe_enable(pe_enable), .pe_dbg_mode_wire(pe_dbg_mode_wire),
    .pe_send_num_wire(pe_send_num_wire), .pe_receive_num_wire(pe_receive_num_wire),
    .pe_rate_wire(pe_rate_wire), .pe_dst_seq_wire(pe_dst_seq_wire),
    .pe_mode_wire(pe_mode_wire), .pe_flush_wire(pe_flush_wire),
    .pe_task_send_finish_flag(sflag), .pe_task_receive_finish_flag(rflag),
    .busy(busy), .done(done), .status(status), .run_cycles(run_cycles),
    .start_err(start_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: a run is "active" from the accepted start; the first
  // FLUSH cycles of it are flush, the rest run until an end condition.
  bit          m_valid = 0;
  bit          m_active;
  int          m_t;
  logic [7:0]  m_mask, m_snd, m_rcv;
  longint      m_run;
  logic [1:0]  m_status;
  bit          m_done, m_err;
  logic [38:0] m_cfg [8];

  task automatic finish_run(input logic [1:0] s);
    m_active = 0;
    m_done   = 1;
    m_status = s;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1; m_active = 0; m_t = 0; m_mask = 0; m_snd = 0; m_rcv = 0;
      m_run = 0; m_status = 0; m_done = 0; m_err = 0;
      for (int i = 0; i < 8; i++) m_cfg[i] = '0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (!m_active) begin
        if (cfg_wr) m_cfg[cfg_pe] = cfg_wdata;
        if (start) begin
          if (start_mask == 8'd0) m_err = 1;
          else begin
            m_active = 1; m_t = 0; m_mask = start_mask; m_status = 0;
            m_run = 0; m_snd = 0; m_rcv = 0;
          end
        end
      end else begin
        if (start) m_err = 1;
        if (m_t < FLUSH) begin
          m_t++;
          if (abort) finish_run(2'd3);
        end else begin
          if (m_run < RUN_MAX) m_run++;
          if (abort) finish_run(2'd3);
          else begin
            m_snd |= sflag & m_mask;
            m_rcv |= rflag & m_mask;
            if (m_snd == m_mask && m_rcv == m_mask) finish_run(2'd1);
            else if (m_run >= TIMEOUT) finish_run(2'd2);
          end
        end
      end
    end
  end

  logic [7:0]   e_dbg;
  logic [23:0]  e_snd, e_rcv;
  logic [31:0]  e_rate, e_mode;
  logic [191:0] e_dst;

  // Every-cycle compare of all outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 8; i++) begin
        e_dbg[i]          = m_cfg[i][38];
        e_snd[3*i +: 3]   = m_cfg[i][37:35];
        e_rcv[3*i +: 3]   = m_cfg[i][34:32];
        e_rate[4*i +: 4]  = m_cfg[i][31:28];
        e_mode[4*i +: 4]  = m_cfg[i][27:24];
        e_dst[24*i +: 24] = m_cfg[i][23:0];
      end
      cmp("m_enable", pe_enable, (m_active && m_t >= FLUSH) ? m_mask : 8'd0);
      cmp("m_flush", pe_flush_wire, (m_active && m_t < FLUSH) ? m_mask : 8'd0);
      cmp("m_busy", busy, m_active);
      cmp("m_done", done, m_done);
      cmp("m_status", status, m_status);
      cmp("m_run_cycles", run_cycles, m_run[31:0]);
      cmp("m_start_err", start_err, m_err);
      cmp("m_dbg", pe_dbg_mode_wire, e_dbg);
      cmp("m_send_num", pe_send_num_wire, e_snd);
      cmp("m_recv_num", pe_receive_num_wire, e_rcv);
      cmp("m_rate", pe_rate_wire, e_rate);
      cmp("m_mode", pe_mode_wire, e_mode);
      cmp("m_dst", pe_dst_seq_wire, e_dst);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_start(input logic [7:0] msk);
    start = 1; start_mask = msk;
    tick();
    start = 0;
    repeat (FLUSH) tick();
  endtask

  initial begin
    rst_n = 0; cfg_wr = 0; cfg_pe = 0; cfg_wdata = 0; start = 0; start_mask = 0;
    abort = 0; sflag = 0; rflag = 0;
    repeat (3) tick();
    cmp("rst_busy", busy, 1'b0);
    cmp("rst_status", status, 2'd0);
    cmp("rst_enable", pe_enable, 8'd0);
    cmp("rst_dst", pe_dst_seq_wire, 192'd0);
    rst_n = 1;
    tick();

    // Basic run: PE0 config, mask 0x03, flags at RUN cycle 26
    cfg_wr = 1; cfg_pe = 0; cfg_wdata = (39'd3 << 35) | (39'd2 << 28) | 39'd1;
    tick();
    cfg_wr = 0;
    cmp("t1_send_num", pe_send_num_wire[2:0], 3'd3);
    cmp("t1_rate", pe_rate_wire[3:0], 4'd2);
    cmp("t1_dst", pe_dst_seq_wire[23:0], 24'd1);
    start = 1; start_mask = 8'h03;
    tick();
    start = 0;
    cmp("t1_flush1", pe_flush_wire, 8'h03);
    cmp("t1_busy", busy, 1'b1);
    repeat (3) tick();
    cmp("t1_flush4", pe_flush_wire, 8'h03);
    cmp("t1_en_during_flush", pe_enable, 8'h00);
    tick();
    cmp("t1_enable", pe_enable, 8'h03);
    cmp("t1_flush_off", pe_flush_wire, 8'h00);
    repeat (25) tick();
    sflag = 8'h03; rflag = 8'h03;
    tick();
    sflag = 0; rflag = 0;
    cmp("t1_done", done, 1'b1);
    cmp("t1_status", status, 2'd1);
    cmp("t1_run_cycles", run_cycles, 32'd26);
    cmp("t1_enable_off", pe_enable, 8'h00);
    tick();
    cmp("t1_done_pulse", done, 1'b0);
    cmp("t1_status_sticky", status, 2'd1);

    // Timeout after TIMEOUT RUN cycles
    run_start(8'h01);
    repeat (TIMEOUT - 1) tick();
    cmp("t2_not_yet", done, 1'b0);
    cmp("t2_en_last", pe_enable, 8'h01);
    tick();
    cmp("t2_done", done, 1'b1);
    cmp("t2_status", status, 2'd2);
    cmp("t2_run_cycles", run_cycles, 32'(TIMEOUT));
    cmp("t2_enable_off", pe_enable, 8'h00);

    // Abort on RUN cycle 3 with a config write attempted during the run
    cfg_wr = 1; cfg_pe = 2; cfg_wdata = 39'd5 << 24;
    tick();
    cfg_wr = 0;
    run_start(8'h0F);
    repeat (2) tick();
    abort = 1; cfg_wr = 1; cfg_pe = 2; cfg_wdata = '1;
    tick();
    abort = 0; cfg_wr = 0;
    cmp("t3_done", done, 1'b1);
    cmp("t3_status", status, 2'd3);
    cmp("t3_enable_off", pe_enable, 8'h00);
    cmp("t3_mode_kept", pe_mode_wire[11:8], 4'd5);
    cmp("t3_dst_kept", pe_dst_seq_wire[71:48], 24'd0);
    tick();

    // Rejected starts: empty mask, then start while busy
    start = 1; start_mask = 8'h00;
    tick();
    start = 0;
    cmp("t4_err_empty", start_err, 1'b1);
    cmp("t4_busy_empty", busy, 1'b0);
    tick();
    cmp("t4_err_pulse", start_err, 1'b0);
    start = 1; start_mask = 8'h01;
    tick();
    start_mask = 8'h02;
    tick();
    start = 0;
    cmp("t4_err_busy", start_err, 1'b1);
    cmp("t4_mask_kept", pe_flush_wire, 8'h01);
    abort = 1;
    tick();
    abort = 0;
    cmp("t4_abort", status, 2'd3);

    // Out-of-mask flags are ignored; split send/recv completion
    sflag = 8'h20; rflag = 8'h20;
    run_start(8'h01);
    repeat (5) tick();
    cmp("t5_no_done", done, 1'b0);
    cmp("t5_busy", busy, 1'b1);
    sflag = 8'h21;
    tick();
    sflag = 8'h20;
    cmp("t5_k1", done, 1'b0);
    repeat (2) tick();
    cmp("t5_k3", done, 1'b0);
    rflag = 8'h21;
    tick();
    sflag = 0; rflag = 0;
    cmp("t5_done", done, 1'b1);
    cmp("t5_status", status, 2'd1);

    // Reset mid-run, then completion coinciding with timeout
    run_start(8'hFF);
    repeat (3) tick();
    rst_n = 0;
    tick();
    cmp("t6_rst_enable", pe_enable, 8'h00);
    cmp("t6_rst_busy", busy, 1'b0);
    cmp("t6_rst_done", done, 1'b0);
    cmp("t6_rst_rate", pe_rate_wire, 32'd0);
    rst_n = 1;
    tick();
    run_start(8'h01);
    repeat (TIMEOUT - 1) tick();
    sflag = 8'h01; rflag = 8'h01;
    tick();
    sflag = 0; rflag = 0;
    cmp("t6_tie_done", done, 1'b1);
    cmp("t6_tie_status", status, 2'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst_n      = ($urandom_range(0, 1499) != 0);
      cfg_wr     = ($urandom_range(0, 7) == 0);
      cfg_pe     = 3'($urandom);
      cfg_wdata  = {7'($urandom), 32'($urandom)};
      start      = ($urandom_range(0, 11) == 0);
      start_mask = 8'($urandom) & 8'($urandom);
      abort      = ($urandom_range(0, 149) == 0);
      sflag      = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rflag      = 8'($urandom) & 8'($urandom) & 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
